// File: rtl/serial_subtractor_8bit.sv
// serial_subtractor_8bit: bit-serial A-B (LSB first) with start/busy/done; define SUB_SAT_EN to saturate at zero
module serial_subtractor_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow,
    output logic             Zero
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_res, r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_br, r_busy, r_done, r_borrow, r_zero;
    logic             w_d, w_br, w_last;
    logic [WIDTH-1:0] w_res, w_final;
    assign w_d    = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br   = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res  = {w_d, r_res[WIDTH-1:1]};
    assign w_last = r_cnt == CW'(WIDTH - 1);
`ifdef SUB_SAT_EN
    assign w_final = w_br ? '0 : w_res;
`else
    assign w_final = w_res;
`endif
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_br     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_next == RUN;
            r_done  <= w_next == DONE;
            if (r_state == IDLE && start) begin
                r_a   <= A;
                r_b   <= B;
                r_cnt <= '0;
                r_br  <= 1'b0;
            end else if (r_state == RUN) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_res <= w_res;
                r_cnt <= r_cnt + 1'b1;
                r_br  <= w_br;
                if (w_last) begin
                    r_diff   <= w_final;
                    r_borrow <= w_br;
                    r_zero   <= w_final == '0;
                end
            end
        end
    end
    assign busy   = r_busy;
    assign done   = r_done;
    assign Diff   = r_diff;
    assign Borrow = r_borrow;
    assign Zero   = r_zero;
endmodule
